// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, flush and saturating stall/bubble counters.
// Define PIPE_SKID_EN for a 2-entry skid buffer that removes the out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              in_fire, out_fire;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid_q, skid_d;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_FULL;
        ST_FULL: begin
`ifdef PIPE_SKID_EN
          if (in_fire && !out_ready)      state_d = ST_SKID;
          else if (out_fire && !in_fire)  state_d = ST_EMPTY;
`else
          if (out_fire && !in_fire)       state_d = ST_EMPTY;
`endif
        end
        ST_SKID:  if (out_fire) state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
`ifdef PIPE_SKID_EN
    in_ready  = ~flush & (state_q != ST_SKID);
`else
    in_ready  = ~flush & (~out_valid | out_ready);
`endif
  end

  // Payload path: a stalled output diverts the incoming beat into the skid entry.
  always_comb begin
    data_d = data_q;
`ifdef PIPE_SKID_EN
    skid_d = skid_q;
    if (flush) begin
      data_d = '0;
      skid_d = '0;
    end else if (state_q == ST_SKID) begin
      if (out_fire) data_d = skid_q;
    end else if (in_fire) begin
      if (out_valid && !out_ready) skid_d = in_data;
      else                         data_d = in_data;
    end
`else
    if (flush)        data_d = '0;
    else if (in_fire) data_d = in_data;
`endif
  end

  // NOTE: payload flops are reset too, so a post-reset bubble reads as an all-zero payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
`ifdef PIPE_SKID_EN
      skid_q <= '0;
`endif
    end else begin
      data_q <= data_d;
`ifdef PIPE_SKID_EN
      skid_q <= skid_d;
`endif
    end
  end

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != '1))  stall_d  = stall_q + 1'b1;
    if (!out_valid && out_ready && (bubble_q != '1)) bubble_d = bubble_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign out_data   = data_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks for pipe_stage_reg; a second instance with CNT_W=2 covers saturation.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] stall_cnt, bubble_cnt;

  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_data;
  logic [1:0]  s_stall_cnt, s_bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] q[$];
  int          m_stall, m_bubble;
  logic        exp_valid, exp_ready;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(64), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_bubble", bubble_cnt, 0);
    check("rst_in_ready", in_ready, 1);
    tick();
    tick();
    rst = 1'b0;

    // Streaming 1..8 with downstream always ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 64'(i);
      #1;
      check("stream_in_ready", in_ready, 1);
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, 64'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_stall", stall_cnt, 0);
    check("stream_bubble", bubble_cnt, 1);

    // Stall: 0xA5 held for 3 cycles while 0xB6 waits upstream
    in_valid = 1'b1;
    in_data  = 64'hA5;
    tick();
    check("stall_first_data", out_data, 64'hA5);
    out_ready = 1'b0;
    in_data   = 64'hB6;
    #1;
`ifdef PIPE_SKID_EN
    check("stall_ready_pre", in_ready, 1);
`else
    check("stall_ready_pre", in_ready, 0);
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 64'hA5);
      check("stall_in_ready", in_ready, 0);
    end
    check("stall_cnt3", stall_cnt, 3);
    check("stall_cnt_sat", s_stall_cnt, 3);
    out_ready = 1'b1;
    #1;
`ifdef PIPE_SKID_EN
    check("release_ready", in_ready, 0);
`else
    check("release_ready", in_ready, 1);
`endif
    tick();
    check("release_valid", out_valid, 1);
    check("release_data", out_data, 64'hB6);
    in_valid = 1'b0;
    tick();
    check("release_drain", out_valid, 0);
    check("release_stall", stall_cnt, 3);
    check("release_bubble", bubble_cnt, 2);

    // Flush while holding 0x3C with 0x77 offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h3C;
    tick();
    check("flush_pre_data", out_data, 64'h3C);
    flush   = 1'b1;
    in_data = 64'h77;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    check("flush_valid", out_valid, 0);
    check("flush_data", out_data, 0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("flush_after_valid", out_valid, 0);
    check("flush_after_data", out_data, 0);
    check("flush_stall", stall_cnt, 4);
    check("flush_stall_sat", s_stall_cnt, 3);
    check("flush_bubble", bubble_cnt, 3);

    // Asynchronous reset while a beat is held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h5A;
    tick();
    check("midrst_pre_valid", out_valid, 1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_stall", stall_cnt, 0);
    check("midrst_bubble", bubble_cnt, 0);
    check("midrst_sat_stall", s_stall_cnt, 0);
    tick();
    rst = 1'b0;

    // Saturation of the 2-bit bubble counter
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) check("sat_bubble_2", s_bubble_cnt, 2);
    end
    check("sat_bubble_hold", s_bubble_cnt, 3);
    check("wide_bubble_6", bubble_cnt, 6);

    // Random traffic against a queue model
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_stall  = 0;
    m_bubble = 0;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      exp_valid = (q.size() != 0);
      check("rnd_valid", out_valid, exp_valid);
      if (exp_valid) check("rnd_data", out_data, q[0]);
      flush     = ($urandom_range(9) == 0);
      in_valid  = ($urandom_range(2) != 0);
      out_ready = ($urandom_range(4) > 1);
      in_data   = {$urandom, $urandom};
      #1;
`ifdef PIPE_SKID_EN
      exp_ready = !flush && (q.size() < 2);
`else
      exp_ready = !flush && ((q.size() == 0) || out_ready);
`endif
      check("rnd_in_ready", in_ready, exp_ready);
      if (exp_valid && !out_ready) m_stall++;
      if (!exp_valid && out_ready) m_bubble++;
      if (flush) begin
        q.delete();
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (exp_ready && in_valid)  q.push_back(in_data);
      end
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("rnd_stall_cnt", stall_cnt, 64'(m_stall));
    check("rnd_bubble_cnt", bubble_cnt, 64'(m_bubble));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
